pllcfg_spi_slave: RTL and testbench
===================================

Name: pllcfg_spi_slave

Overview:
SPI slave that consumes the serial stream produced by the PLL-configuration SPI master (CPOL=0, CPHA=0, MSB first, one slave select) and turns it into register-file accesses for the PLL reconfiguration logic. The slave runs on the fabric system clock and oversamples SCLK/SS_n/MOSI. It decodes 32-bit frames of {rw, addr[14:0], data[15:0]} and issues single-cycle write or read strobes. On reads it returns the data word on MISO in the same frame.

Parameters:
ADDR_W, 8, width of reg_addr; frame address bits [14:ADDR_W] are ignored (1..15)
SYNC_STAGES, 2, synchroniser depth on SCLK, SS_n, MOSI (2..3)

Ports:
clk  in  1  system clock; must be >= 8x SCLK frequency
reset  in  1  asynchronous, active-high reset
SCLK  in  1  SPI clock from master, async to clk
SS_n  in  1  slave select, active low, async to clk
MOSI  in  1  serial data from master, async to clk
MISO  out  1  serial data to master
reg_addr  out  ADDR_W  access address, held stable from strobe until next frame's address phase ends
reg_wdata  out  16  write data, valid with reg_wr
reg_wr  out  1  one-clk write strobe
reg_rd  out  1  one-clk read strobe
reg_rdata  in  16  read data, sampled exactly 1 clk after reg_rd
frame_err  out  1  one-clk pulse on aborted frame

Behaviour:
- Reset values: MISO=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, frame_err=0; FSM=IDLE, bit counter=0, shift registers=0.
- SCLK, SS_n and MOSI each pass through SYNC_STAGES flops. Synchroniser reset values: SCLK=0, SS_n=1, MOSI=0.
- Edge detect on the synchronised SCLK gives rise and fall pulses. Edges are ignored while synchronised SS_n=1.
- MOSI is sampled on rise into a 16-bit rx shift register. MISO is the MSB of a tx shift register, which shifts on fall.
- FSM states:
  - IDLE -> ADDR on SS_n falling (synchronised). tx shift register loaded with 0.
  - ADDR: on each rise, shift in and bitcnt++. When the 16th bit arrives, latch rw=rx[15] and reg_addr=rx[ADDR_W-1:0]. If rw=0, pulse reg_rd the same clk, capture reg_rdata 1 clk later into tx shift, and hold MISO at reg_rdata[15] until the next fall. Go to DATA.
  - DATA: on each rise, shift in. When the 32nd bit arrives and rw=1, set reg_wdata=rx and pulse reg_wr 1 clk later. Go to DONE.
  - DONE: further edges are ignored and MISO=0 (burst feature excepted). Go to IDLE on SS_n rise.
- Read data timing: the first read bit is presented before the 17th rise. The minimum rise-to-fall spacing is 4 clk at the 8x ratio, which covers the 2-clk rd latency.
- During an address phase, and for the data phase of a write, MISO outputs 0.
- SS_n rise in ADDR or DATA aborts the frame:
  - no reg_wr is issued;
  - any reg_rd already issued stands;
  - frame_err pulses 1 clk;
  - FSM goes to IDLE and bitcnt clears.
- SS_n rise and a rise edge in the same clk: SS_n wins and the bit is discarded.
- SS_n low at reset release (synchronised): the FSM stays in IDLE until SS_n returns high, then waits for the next fall. The partial frame is not decoded.
- Back-to-back frames: SS_n high for >= SYNC_STAGES+1 clk is enough to start a new frame.
- reg_wr and reg_rd are never asserted in the same clk.

Optional Feature:
PLLCFG_SPI_BURST_EN
- Defined: DONE is replaced by a burst loop. Each further 16 bits after bit 32 form another data word at reg_addr+1 (wraps modulo 2^ADDR_W).
  - Write frames: reg_wr per completed word.
  - Read frames: reg_rd is issued on the rise completing bit 16+16k, for the next address, and the word is shifted out during the following 16 bits.
  - A partial trailing word at SS_n rise is discarded without frame_err.
- Not defined: no burst; bits beyond 32 are ignored and MISO=0.

Test Plan:
- Write frame 0x8005_1234, SCLK = clk/10 -> exactly one reg_wr with reg_addr=0x05, reg_wdata=0x1234; reg_rd never asserted; frame_err=0.
- Read frame 0x0003_xxxx with reg_rdata=0xA55A when reg_addr=0x03 -> one reg_rd; MISO bits sampled on rises 17..32 equal 0xA55A MSB first; MISO=0 on bits 1..16.
- Write frame 0x8010_FFFF with SS_n raised after 20 bits -> no reg_wr; frame_err pulses once; following full write 0x8011_0001 executes normally.
- Assert reset mid-DATA of a write -> all outputs return to reset values immediately; no reg_wr after release; next full frame is decoded correctly.
- Two write frames with SS_n high for 3 clk between, addresses 0x7F and 0x00, ADDR_W=8 -> two reg_wr with correct addr/data. Address 0xFFFF with ADDR_W=8 -> reg_addr=0xFF.
- With PLLCFG_SPI_BURST_EN: write 0x80FE, then data 0x0001, 0x0002, 0x0003 -> reg_wr at addr 0xFE, 0xFF, 0x00 with those data. Without the macro: a single reg_wr at 0xFE.

Source files
------------

// File: rtl/pllcfg_spi_slave.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) decoding 32-bit {rw, addr, data} frames into register strobes.
// Optional burst mode: define PLLCFG_SPI_BURST_EN to continue with auto-incremented words after bit 32.
module pllcfg_spi_slave #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [15:0]       reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [15:0]       reg_rdata,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_d, ss_d;
  logic [1:0]             fill;
  logic                   ss_seen;
  logic                   rise_c, fall_c, ss_fall_c, ss_rise_c;

  state_t      state;
  logic [4:0]  bitcnt;
  logic [15:0] rx, tx, rx_next;
  logic        rw, burst_any, wr_pend, rd_pend;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // A start is only accepted after a genuinely synchronised high SS_n has been seen,
  // so a select held low across reset release never decodes its partial frame.
  assign ss_fall_c = ss_seen & ss_d & ~ss_s;
  assign ss_rise_c = ~ss_d & ss_s;
  assign rise_c    = sclk_s & ~sclk_d & ~ss_s;
  assign fall_c    = ~sclk_s & sclk_d & ~ss_s;
  assign rx_next   = {rx[14:0], mosi_s};

  // Input synchronisers and edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      fill      <= 2'd0;
      ss_seen   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      if (fill != 2'(SYNC_STAGES)) fill <= fill + 2'd1;
      if (fill == 2'(SYNC_STAGES) && ss_s) ss_seen <= 1'b1;
    end
  end

  // Frame FSM with registered strobes and shift registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bitcnt    <= 5'd0;
      rx        <= 16'h0;
      tx        <= 16'h0;
      rw        <= 1'b0;
      burst_any <= 1'b0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      MISO      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 16'h0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr    <= wr_pend;
      wr_pend   <= 1'b0;
      reg_rd    <= 1'b0;
      rd_pend   <= reg_rd;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          bitcnt <= 5'd0;
          if (ss_fall_c) begin
            state <= ADDR;
            rx    <= 16'h0;
            tx    <= 16'h0;
            MISO  <= 1'b0;
          end
        end

        ADDR: begin
          if (ss_rise_c) begin
            state     <= IDLE;
            bitcnt    <= 5'd0;
            frame_err <= 1'b1;
            tx        <= 16'h0;
            MISO      <= 1'b0;
          end else if (rise_c) begin
            rx     <= rx_next;
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd15) begin
              rw        <= rx_next[15];
              reg_addr  <= rx_next[ADDR_W-1:0];
              reg_rd    <= ~rx_next[15];
              burst_any <= 1'b0;
              state     <= DATA;
            end
          end else if (fall_c) begin
            MISO <= tx[15];
            tx   <= {tx[14:0], 1'b0};
          end
        end

        DATA: begin
          if (ss_rise_c) begin
            // After at least one burst word, a trailing partial word is just dropped
            state     <= IDLE;
            bitcnt    <= 5'd0;
            frame_err <= ~burst_any;
            tx        <= 16'h0;
            MISO      <= 1'b0;
          end else if (rise_c) begin
            rx     <= rx_next;
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd31) begin
              if (rw) begin
                reg_wdata <= rx_next;
                wr_pend   <= 1'b1;
              end
`ifdef PLLCFG_SPI_BURST_EN
              bitcnt    <= 5'd16;
              burst_any <= 1'b1;
              if (!rw) begin
                reg_addr <= reg_addr + ADDR_W'(1);
                reg_rd   <= 1'b1;
              end else if (burst_any) begin
                reg_addr <= reg_addr + ADDR_W'(1);
              end
`else
              state <= DONE;
              tx    <= 16'h0;
              MISO  <= 1'b0;
`endif
            end
          end else if (fall_c) begin
            MISO <= tx[15];
            tx   <= {tx[14:0], 1'b0};
          end
        end

        DONE: begin
          MISO <= 1'b0;
          if (ss_rise_c) begin
            state  <= IDLE;
            bitcnt <= 5'd0;
          end
        end

        default: state <= IDLE;
      endcase

      // Read data lands one clk after the strobe; MISO presents its MSB until the next fall
      if (rd_pend && state == DATA && !ss_rise_c) begin
        tx   <= reg_rdata;
        MISO <= reg_rdata[15];
      end
    end
  end

endmodule

// File: tb/tb_pllcfg_spi_slave.sv
// Scoreboard bench for pllcfg_spi_slave: randomized SPI frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_pllcfg_spi_slave;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
`ifdef PLLCFG_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } ev_t;

  logic clk, reset, SCLK, SS_n, MOSI, MISO;
  logic [ADDR_W-1:0] reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic reg_wr, reg_rd, frame_err;

  pllcfg_spi_slave #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t         exp_q[$];
  logic [15:0] mem [2**ADDR_W];
  int          checks = 0, errors = 0;
  logic [63:0] exp_miso, miso_obs;
  int          exp_n, miso_n;
  logic        frame_tick = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input logic [1:0] k, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event", 64'({k, a, d}), 64'({e.kind, e.addr, e.data}));
    end
  endtask

  // Register file responder: data valid exactly the clk after reg_rd, noise otherwise
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
    else        reg_rdata <= 16'($urandom);
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr && reg_rd) check("wr_rd_same_clk", 64'(1), 64'(0));
      if (reg_wr)    pop_cmp(EV_WR, reg_addr, reg_wdata);
      if (reg_rd)    pop_cmp(EV_RD, reg_addr, 16'h0);
      if (frame_err) pop_cmp(EV_ERR, '0, 16'h0);
    end
  end

  // MISO monitor: samples on every SCLK rise, compares the stream at frame end
  always @(posedge SCLK or frame_tick) begin
    if (!SS_n) begin
      miso_obs = {miso_obs[62:0], MISO};
      miso_n++;
    end else begin
      check("miso_bits", miso_obs, exp_miso);
      check("miso_count", 64'(miso_n), 64'(exp_n));
      miso_obs = 64'h0;
      miso_n   = 0;
    end
  end

  // One SPI frame of n bits (f left-aligned); rst_at>0 asserts reset after that many bits
  task automatic send_frame(input logic [63:0] f, input int n, input int hp, input int rst_at, input int gap);
    logic              rwb;
    logic [ADDR_W-1:0] base;
    logic [63:0]       em;
    logic [15:0]       w;
    logic              bv;
    int                j, sent;
    rwb  = f[63];
    base = f[48 +: ADDR_W];
    em   = 64'h0;
    for (int b = 1; b <= n; b++) begin
      bv = 1'b0;
      if (!rwb && b > 16) begin
        j = (b - 17) / 16;
        if (BURST || j == 0) begin
          w  = mem[ADDR_W'(int'(base) + j)];
          bv = w[15 - ((b - 17) % 16)];
        end
      end
      em = {em[62:0], bv};
    end
    if (rst_at == 0) begin
      if (!rwb && n >= 16) push(EV_RD, base, 16'h0);
      for (int k = 0; k < 3; k++) begin
        if (k == 0 || BURST) begin
          if (rwb && n >= 32 + 16 * k) begin
            w = f[47 - 16 * k -: 16];
            push(EV_WR, ADDR_W'(int'(base) + k), w);
            mem[ADDR_W'(int'(base) + k)] = w;
          end
          if (!rwb && k > 0 && n >= 16 + 16 * k) push(EV_RD, ADDR_W'(int'(base) + k), 16'h0);
        end
      end
      if (n < 32) push(EV_ERR, '0, 16'h0);
    end
    sent = n;
    @(negedge clk); SS_n = 1'b0;
    for (int b = 0; b < n; b++) begin
      MOSI = f[63 - b];
      repeat (hp) @(negedge clk);
      SCLK = 1'b1;
      repeat (hp) @(negedge clk);
      SCLK = 1'b0;
      if (rst_at == b + 1) begin
        sent = rst_at;
        break;
      end
    end
    if (rst_at > 0) begin
      em = em >> (n - sent);
      #2 reset = 1'b1;
      #1 check("outputs_in_reset", 64'({MISO, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err}), 64'(0));
      SS_n = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
    end else begin
      repeat (hp) @(negedge clk);
      SS_n = 1'b1;
    end
    exp_miso = em; exp_n = sent;
    frame_tick = ~frame_tick;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [63:0] f;
    int n, r;
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f;
    int n, r;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'($urandom);
    miso_obs = 64'h0; miso_n = 0; exp_miso = 64'h0; exp_n = 0;
    reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0; reg_rdata = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({MISO, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err}), 64'(0));
    reset = 1'b0;
    repeat (6) @(negedge clk);

    send_frame({32'h8005_1234, 32'h0}, 32, 5, 0, 6);
    mem[3] = 16'hA55A;
    send_frame({32'h0003_BEEF, 32'h0}, 32, 5, 0, 6);
    send_frame({32'h8010_FFFF, 32'h0}, 20, 5, 0, 6);
    send_frame({32'h8011_0001, 32'h0}, 32, 5, 0, 6);
    send_frame({32'h8020_5555, 32'h0}, 32, 5, 24, 6);
    send_frame({32'h8021_4321, 32'h0}, 32, 4, 0, 3);
    send_frame({32'h807F_AAAA, 32'h0}, 32, 4, 0, 3);
    send_frame({32'h8000_5555, 32'h0}, 32, 4, 0, 3);
    send_frame({32'hFFFF_1111, 32'h0}, 32, 4, 0, 6);
    send_frame({32'h80FE_0001, 32'h0002_0003}, 64, 5, 0, 6);
    send_frame({32'h00FE_0000, 32'h0}, 64, 5, 0, 6);

    // Select held low across reset release must not decode anything
    reset = 1'b1; SS_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      MOSI = 1'($urandom);
      repeat (4) @(negedge clk); SCLK = 1'b1;
      repeat (4) @(negedge clk); SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    SS_n = 1'b1;
    exp_miso = 64'h0; exp_n = 10;
    frame_tick = ~frame_tick;
    repeat (4) @(negedge clk);
    send_frame({32'h8042_CAFE, 32'h0}, 32, 4, 0, 4);

    for (int i = 0; i < 40; i++) begin
      f = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      if (r < 2)       n = $urandom_range(1, 31);
      else if (r < 4)  n = $urandom_range(33, 64);
      else             n = 32;
      send_frame(f, n, $urandom_range(4, 6), 0, $urandom_range(3, 6));
    end

    repeat (20) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
